// File: rtl/beat_pkg.sv
// Shared types and constants for the beat-rate calculator.
// Holds the FSM state enum, the divider/converter cycle counts,
// the 3-digit BCD type and the add-3 helper used by double-dabble.
package beat_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIVIDE,
    S_CONVERT,
    S_UPDATE
  } state_t;

  localparam int DIV_CYCLES = 16;
  localparam int BCD_CYCLES = 8;

  typedef logic [11:0] bcd3_t;

  // Add 3 to every BCD digit that is 5 or more (double-dabble correction).
  function automatic bcd3_t bcd_add3(input bcd3_t d);
    bcd3_t r;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = (d[i*4 +: 4] >= 4'd5) ? d[i*4 +: 4] + 4'd3 : d[i*4 +: 4];
    end
    return r;
  endfunction

endpackage

// File: rtl/bin_to_bcd3.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble).
// A start pulse loads the value and performs the first shift in the
// same clock; the remaining shifts follow one per clock, and done
// pulses for one clock when bcd holds the final result.
module bin_to_bcd3
  import beat_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);

  localparam logic [2:0] STEPS_AFTER_LOAD = 3'(BCD_CYCLES - 1);

  logic [7:0]  bin_sr;
  logic [2:0]  steps_left;
  logic [11:0] bcd_adj;

  // Digit correction for the current shift step.
  // NOTE: combinational blocks assign every output on every path, so no latch is inferred.
  always_comb begin
    bcd_adj = bcd_add3(bcd);
  end

  // Load on start, then one correct-and-shift step per clock.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd        <= '0;
      bin_sr     <= '0;
      steps_left <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bcd        <= {11'd0, bin[7]};
        bin_sr     <= {bin[6:0], 1'b0};
        steps_left <= STEPS_AFTER_LOAD;
      end else if (steps_left != 3'd0) begin
        bcd        <= {bcd_adj[10:0], bin_sr[7]};
        bin_sr     <= {bin_sr[6:0], 1'b0};
        steps_left <= steps_left - 3'd1;
        if (steps_left == 3'd1) done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/beat_rate_calc.sv
// Heart-rate calculator: measures the interval between accepted peak
// edges in sample ticks, divides 60*SAMPLE_RATE by it (restoring, 16
// clks), converts the clamped quotient to BCD (8 clks) and publishes it.
// Optional macro BEAT_AVG_EN averages the last four accepted intervals.
module beat_rate_calc
  import beat_pkg::*;
#(
  parameter int SAMPLE_RATE     = 500,
  parameter int REFRACT_SAMPLES = 150,
  parameter int MAX_SAMPLES     = 1000,
  parameter int LED_TICKS       = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_tick,
  input  logic        peak,
  output logic [11:0] bpm_bcd,
  output logic        bpm_valid,
  output logic        beat_led,
  output logic        no_signal
);

  localparam logic [15:0] DIVIDEND  = 16'(60 * SAMPLE_RATE);
  localparam logic [10:0] CNT_REF   = 11'(REFRACT_SAMPLES);
  localparam logic [10:0] CNT_MAX   = 11'(MAX_SAMPLES);
  localparam logic [10:0] CNT_SAT   = 11'(MAX_SAMPLES + 1);
  localparam int          LED_W     = $clog2(LED_TICKS + 1);
  localparam logic [3:0]  DIV_LAST  = 4'(DIV_CYCLES - 1);

  state_t            state;
  logic              peak_d;
  logic              armed;
  logic              pending;
  logic [10:0]       cnt;
  logic [10:0]       divisor_sel;
  logic [LED_W-1:0]  led_cnt;
  logic              rise, accept, arm_evt, clear, timeout;

  logic [3:0]  div_cnt;
  logic [11:0] rem;
  logic [15:0] quo;
  logic [10:0] dvsr;
  logic [11:0] rem_sh, rem_nx;
  logic [12:0] diff;
  logic [15:0] quo_nx;
  logic        q_bit;
  logic [7:0]  conv_bin;
  logic        conv_start, conv_done;
  logic [11:0] conv_bcd;

  assign rise    = peak & ~peak_d;
  assign accept  = rise & armed & (cnt >= CNT_REF) & (cnt <= CNT_MAX);
  assign arm_evt = rise & ~armed;
  assign clear   = accept | arm_evt;
  assign timeout = armed & ~accept & sample_tick & (cnt == CNT_MAX);

  // Previous peak level for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) peak_d <= 1'b0;
    else       peak_d <= peak;
  end

  // Interval counter: clears on arm/accept (to 1 if a tick coincides), saturates at MAX+1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                cnt <= '0;
    else if (clear)                           cnt <= sample_tick ? 11'd1 : 11'd0;
    else if (sample_tick && cnt != CNT_SAT)   cnt <= cnt + 11'd1;
  end

  // Armed flag: set by the first edge, dropped when the interval times out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        armed <= 1'b0;
    else if (clear)   armed <= 1'b1;
    else if (timeout) armed <= 1'b0;
  end

  // Pending request: set by an accepted edge, consumed by LOAD or dropped on timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               pending <= 1'b0;
    else if (accept)                         pending <= 1'b1;
    else if (timeout || state == S_LOAD)     pending <= 1'b0;
  end

`ifdef BEAT_AVG_EN
  logic [10:0] hist [4];
  logic        fresh;
  logic [12:0] hist_sum;

  // Divisor is the mean of the four most recent accepted intervals.
  always_comb begin
    hist_sum    = 13'(hist[0]) + 13'(hist[1]) + 13'(hist[2]) + 13'(hist[3]);
    divisor_sel = 11'(hist_sum >> 2);
  end

  // Interval history: the first accept after arming fills all four entries.
  // NOTE: the history is small and feeds the divisor directly, so it is reset rather than left undefined.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) hist[i] <= '0;
      fresh <= 1'b0;
    end else if (arm_evt) begin
      fresh <= 1'b1;
    end else if (accept) begin
      fresh <= 1'b0;
      if (fresh) begin
        for (int i = 0; i < 4; i++) hist[i] <= cnt;
      end else begin
        hist[3] <= hist[2];
        hist[2] <= hist[1];
        hist[1] <= hist[0];
        hist[0] <= cnt;
      end
    end
  end
`else
  logic [10:0] interval;

  // Latest accepted interval; a newer accept overwrites an unserviced one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       interval <= '0;
    else if (accept) interval <= cnt;
  end

  // Divisor is the latest accepted interval.
  always_comb begin
    divisor_sel = interval;
  end
`endif

  // One restoring-division step and the clamped final quotient for the converter.
  always_comb begin
    rem_sh     = {rem[10:0], quo[15]};
    diff       = {1'b0, rem_sh} - {2'b00, dvsr};
    q_bit      = ~diff[12];
    rem_nx     = q_bit ? diff[11:0] : rem_sh;
    quo_nx     = {quo[14:0], q_bit};
    conv_bin   = (quo_nx > 16'd255) ? 8'hFF : quo_nx[7:0];
    conv_start = (state == S_DIVIDE) && (div_cnt == DIV_LAST);
  end

  bin_to_bcd3 u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (conv_bin),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Control FSM with registered result outputs; a timeout aborts and blanks the display.
  // Results are latched on the edge that enters UPDATE, 26 clks after the accepted edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      rem       <= '0;
      quo       <= '0;
      dvsr      <= '0;
      bpm_bcd   <= '0;
      bpm_valid <= 1'b0;
      no_signal <= 1'b1;
    end else if (timeout) begin
      state     <= S_IDLE;
      bpm_bcd   <= '0;
      bpm_valid <= 1'b0;
      no_signal <= 1'b1;
    end else begin
      if (accept) no_signal <= 1'b0;
      case (state)
        S_IDLE: if (pending) state <= S_LOAD;
        S_LOAD: begin
          quo     <= DIVIDEND;
          rem     <= '0;
          dvsr    <= divisor_sel;
          div_cnt <= '0;
          state   <= S_DIVIDE;
        end
        S_DIVIDE: begin
          rem     <= rem_nx;
          quo     <= quo_nx;
          div_cnt <= div_cnt + 4'd1;
          if (div_cnt == DIV_LAST) state <= S_CONVERT;
        end
        S_CONVERT: begin
          if (conv_done) begin
            bpm_bcd   <= conv_bcd;
            bpm_valid <= 1'b1;
            state     <= S_UPDATE;
          end
        end
        S_UPDATE: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Beat LED stretch: restarted by every accepted edge, runs LED_TICKS sample ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_led <= 1'b0;
      led_cnt  <= '0;
    end else if (accept) begin
      beat_led <= 1'b1;
      led_cnt  <= LED_W'(LED_TICKS);
    end else if (sample_tick && led_cnt != '0) begin
      led_cnt <= led_cnt - LED_W'(1);
      if (led_cnt == LED_W'(1)) beat_led <= 1'b0;
    end
  end

endmodule

// File: tb/tb_beat_rate_calc.sv
// Self-checking bench for beat_rate_calc (default parameters).
// Directed scenarios plus randomized beat spacing, compared against a
// tick-level behavioural model of intervals, history and BPM arithmetic.
module tb_beat_rate_calc;

  localparam int SR   = 500;
  localparam int REF  = 150;
  localparam int MAXS = 1000;
  localparam int LEDT = 50;
  localparam int LAT  = 26;
`ifdef BEAT_AVG_EN
  localparam bit AVG = 1'b1;
  localparam logic [11:0] EXP_AVG_FINAL = 12'h060;
  localparam logic [11:0] EXP_COINC     = 12'h068;
`else
  localparam bit AVG = 1'b0;
  localparam logic [11:0] EXP_AVG_FINAL = 12'h050;
  localparam logic [11:0] EXP_COINC     = 12'h200;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_tick = 1'b0;
  logic        peak = 1'b0;
  logic [11:0] bpm_bcd;
  logic        bpm_valid, beat_led, no_signal;

  beat_rate_calc dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .peak        (peak),
    .bpm_bcd     (bpm_bcd),
    .bpm_valid   (bpm_valid),
    .beat_led    (beat_led),
    .no_signal   (no_signal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_armed, m_fresh, m_valid, m_nosig;
  int          m_elapsed, m_led, lat;
  int          m_hist[$];
  logic [11:0] m_bcd, res_bcd;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_armed = 0; m_fresh = 0; m_valid = 0; m_nosig = 1;
    m_elapsed = 0; m_led = 0; lat = -1; m_bcd = '0; res_bcd = '0;
    m_hist.delete();
  endtask

  // One sample tick that is not cleared by an edge.
  task automatic model_tick();
    if (m_led > 0) begin
      m_led--;
      if (m_led == 0)      check("led_off", beat_led, 0);
      else if (m_led == 1) check("led_on", beat_led, 1);
    end
    if (m_elapsed <= MAXS) m_elapsed++;
    if (m_armed && m_elapsed == MAXS + 1) begin
      m_armed = 0; m_valid = 0; m_bcd = '0; m_nosig = 1; lat = -1;
      check("timeout_no_signal", no_signal, 1);
      check("timeout_valid", bpm_valid, 0);
      check("timeout_bcd", bpm_bcd, 0);
    end
  endtask

  // Advance one clock; track the result latency window.
  task automatic clk_step(input bit tk, input bit pk);
    sample_tick = tk;
    peak        = pk;
    @(posedge clk);
    #1;
    if (lat >= 0) begin
      lat++;
      if (lat == LAT - 1) begin
        check("pre_update_valid", bpm_valid, m_valid);
        check("pre_update_bcd", bpm_bcd, m_bcd);
      end else if (lat == LAT) begin
        m_bcd = res_bcd; m_valid = 1; lat = -1;
        check("update_valid", bpm_valid, 1);
        check("update_bcd", bpm_bcd, m_bcd);
      end
    end
    if (tk && !pk) model_tick();
  endtask

  task automatic advance(input int n);
    repeat (n) begin
      clk_step(1'b1, 1'b0);
      clk_step(1'b0, 1'b0);
    end
  endtask

  task automatic drain();
    repeat (LAT + 4) clk_step(1'b0, 1'b0);
  endtask

  // Apply the rules for a rising edge (optionally coincident with a tick).
  task automatic edge_model(input bit tk);
    int iv, dv, q, sum;
    if (m_armed && m_elapsed >= REF && m_elapsed <= MAXS) begin
      iv = m_elapsed;
      m_elapsed = tk ? 1 : 0;
      m_led = LEDT;
      m_nosig = 0;
      if (AVG) begin
        if (m_fresh) begin
          m_hist.delete();
          repeat (4) m_hist.push_back(iv);
          m_fresh = 0;
        end else begin
          m_hist.push_back(iv);
          void'(m_hist.pop_front());
        end
        sum = 0;
        foreach (m_hist[i]) sum += m_hist[i];
        dv = sum / 4;
      end else begin
        dv = iv;
      end
      q = (60 * SR) / dv;
      if (q > 255) q = 255;
      res_bcd = to_bcd(q);
      lat = 0;
    end else begin
      if (!m_armed) begin
        m_armed = 1; m_fresh = 1; m_elapsed = tk ? 1 : 0;
      end else if (tk) begin
        m_elapsed++;
      end
      if (tk && m_led > 0) m_led--;
    end
    check("edge_beat_led", beat_led, (m_led > 0) ? 1 : 0);
    check("edge_no_signal", no_signal, m_nosig);
    check("edge_valid", bpm_valid, m_valid);
    check("edge_bcd", bpm_bcd, m_bcd);
  endtask

  // Wait n ticks, then present a one-clock peak pulse.
  task automatic beat(input int n, input bit tk_edge);
    advance(n);
    clk_step(tk_edge, 1'b1);
    edge_model(tk_edge);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bcd"}, bpm_bcd, 0);
    check({tag, "_valid"}, bpm_valid, 0);
    check({tag, "_led"}, beat_led, 0);
    check({tag, "_no_signal"}, no_signal, 1);
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // First edge arms only; 500-tick spacing, then 250 and 375
    beat(500, 1'b0);
    drain();
    check("arm_no_update", bpm_valid, 0);
    beat(500, 1'b0);
    beat(250, 1'b0);
    beat(375, 1'b0);
    // Refractory edge ignored, then accepted at 500 total
    beat(100, 1'b0);
    beat(400, 1'b0);
    // Timeout, re-arm, then a normal beat
    advance(1001);
    beat(20, 1'b0);
    beat(500, 1'b0);
    drain();
    check("rearm_bcd", bpm_bcd, 12'h060);
    // Averaging scenario from a fresh arm
    advance(1001);
    beat(20, 1'b0);
    beat(400, 1'b0);
    beat(400, 1'b0);
    beat(600, 1'b0);
    beat(600, 1'b0);
    drain();
    check("avg_final", bpm_bcd, EXP_AVG_FINAL);
    // Edge coincident with a tick clears the counter to 1
    beat(400, 1'b1);
    beat(149, 1'b0);
    drain();
    check("coincident_bcd", bpm_bcd, EXP_COINC);

    // Reset in the middle of the divide
    beat(500, 1'b0);
    repeat (5) clk_step(1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_reset_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (40) clk_step(1'b0, 1'b0);
    check("mid_reset_no_update", bpm_valid, 0);

    // Randomized spacing, occasionally coincident with a tick
    beat(30, 1'b0);
    for (int i = 0; i < 18; i++) begin
      beat(int'($urandom_range(100, 1100)), ($urandom_range(0, 3) == 0));
    end
    drain();
    check("final_bcd", bpm_bcd, m_bcd);
    check("final_valid", bpm_valid, m_valid);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
